// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter and its schedulers.
// The FSM state encoding is fixed so it stays stable across reuse.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Channel count derived from the select width.
  function automatic int numChannels(input int nBits);
    return 1 << nBits;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: finds the first eligible channel
// after 'last', wrapping modulo N, so the most recent winner is scanned last.
module rr_pick
  import mux_rr_arbiter_pkg::*;
#(
  parameter int n_bits = 2
) (
  input  logic [numChannels(n_bits)-1:0] elig,
  input  logic [n_bits-1:0]              last,
  output logic [n_bits-1:0]              pick,
  output logic                           any
);

  localparam int N = numChannels(n_bits);

  logic [n_bits-1:0] idx;

  always_comb begin
    pick = last;
    any  = 1'b0;
    idx  = '0;
    for (int i = 0; i < N; i++) begin
      idx = last + n_bits'(i + 1);
      if (!any && elig[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the sniffer's N-to-1 channel mux: holds a registered
// select/grant until done, withdraw, or the hold-time watchdog releases it.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int n_bits   = 2,
  parameter int hold_max = 255,
  parameter int cnt_bits = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [numChannels(n_bits)-1:0] req,
  input  logic [numChannels(n_bits)-1:0] en_mask,
  input  logic                           done,
  output logic [n_bits-1:0]              sel,
  output logic [numChannels(n_bits)-1:0] gnt,
  output logic                           busy,
  output logic                           timeout
);

  localparam int N = numChannels(n_bits);
  localparam bit WdEn = (hold_max != 0);
  localparam logic [cnt_bits-1:0] HoldLast = WdEn ? cnt_bits'(hold_max - 1) : '0;
  localparam logic [N-1:0] OneHotZero = {{(N-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [n_bits-1:0]   sel_q, sel_d;
  logic [n_bits-1:0]   last_q, last_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [cnt_bits-1:0] cnt_q, cnt_d;

  logic [N-1:0]        elig;
  logic [n_bits-1:0]   pick;
  logic                anyElig;
  logic                relDone, relWithdraw, relWatchdog, release_;

  assign elig = req & en_mask;

  rr_pick #(
    .n_bits(n_bits)
  ) u_pick (
    .elig(elig),
    .last(last_q),
    .pick(pick),
    .any (anyElig)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      last_q    <= n_bits'(N - 1);
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Release causes in priority order; done beats the watchdog in the last cycle.
  always_comb begin
    relDone     = 1'b0;
    relWithdraw = 1'b0;
    relWatchdog = 1'b0;
    if (state_q == ST_GRANT) begin
      if (done) begin
        relDone = 1'b1;
      end else if (!req[sel_q] || !en_mask[sel_q]) begin
        relWithdraw = 1'b1;
      end else if (WdEn && (cnt_q == HoldLast)) begin
        relWatchdog = 1'b1;
      end
    end
    release_ = relDone | relWithdraw | relWatchdog;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (anyElig)  state_d = ST_GRANT;
      ST_GRANT: if (release_) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d     = sel_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (anyElig) begin
          sel_d  = pick;
          gnt_d  = OneHotZero << pick;
          busy_d = 1'b1;
          cnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (release_) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          last_d    = sel_q;
          timeout_d = relWatchdog;
        end else begin
          cnt_d = WdEn ? cnt_q + 1'b1 : '0;
        end
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (n_bits=2, hold_max=4): a vector table
// for arbitration/masking plus hand sequences for reset and watchdog timing.
module tb_mux_rr_arbiter;

  localparam int NB = 2;
  localparam int N  = 4;

  logic          clk;
  logic          rstn;
  logic [N-1:0]  req;
  logic [N-1:0]  en_mask;
  logic          done;
  logic [NB-1:0] sel;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          timeout;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  en;
    logic          done;
    logic [N-1:0]  expGnt;
    logic [NB-1:0] expSel;
    logic          expBusy;
    logic          expTo;
  } vec_t;

  vec_t vecs[24];

  mux_rr_arbiter #(
    .n_bits  (NB),
    .hold_max(4),
    .cnt_bits(8)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .en_mask(en_mask),
    .done   (done),
    .sel    (sel),
    .gnt    (gnt),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] e, input logic d);
    req     = r;
    en_mask = e;
    done    = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compareOne(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] eGnt, input logic [NB-1:0] eSel,
                             input logic eBusy, input logic eTo);
    compareOne({tag, " gnt"}, 8'(gnt), 8'(eGnt));
    compareOne({tag, " sel"}, 8'(sel), 8'(eSel));
    compareOne({tag, " busy"}, 8'(busy), 8'(eBusy));
    compareOne({tag, " timeout"}, 8'(timeout), 8'(eTo));
    compareOne({tag, " onehot0"}, 8'($onehot0(gnt)), 8'd1);
    compareOne({tag, " gnt_sel"}, 8'((gnt == '0) || gnt[sel]), 8'd1);
    compareOne({tag, " busy_eq"}, 8'(busy), 8'(gnt != '0));
  endtask

  initial begin
    // req, en, done -> gnt, sel, busy, timeout (outputs after the following edge)
    vecs[0]  = '{4'b0001, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0001, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0001, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0001, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{4'b0001, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[7]  = '{4'b1111, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[9]  = '{4'b1111, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[11] = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[14] = '{4'b0010, 4'b1101, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[15] = '{4'b0010, 4'b1101, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[16] = '{4'b0010, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[17] = '{4'b0010, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[18] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[19] = '{4'b0010, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[20] = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[21] = '{4'b1111, 4'b1101, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[22] = '{4'b1111, 4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[23] = '{4'b1111, 4'b1101, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};

    // Reset with every channel requesting, then first grant goes to channel 0
    rstn = 1'b0;
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    tick();
    tick();
    checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rstn = 1'b1;
    tick();
    checkOutput("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    rstn = 1'b0;
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    checkOutput("reset2", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].req, vecs[i].en, vecs[i].done);
      tick();
      checkOutput($sformatf("row%0d", i), vecs[i].expGnt, vecs[i].expSel, vecs[i].expBusy, vecs[i].expTo);
    end

    // Watchdog: channel 2 alone, no done -> 4 grant cycles then a timeout pulse
    applyStimulus(4'b0100, 4'b1111, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("wd_cycle%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    checkOutput("wd_release", 4'b0000, 2'd2, 1'b0, 1'b1);
    tick();
    checkOutput("wd_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("wd2_cycle4", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0100, 4'b1111, 1'b1);
    tick();
    checkOutput("wd2_done_release", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant to channel 3
    applyStimulus(4'b1000, 4'b1111, 1'b0);
    tick();
    checkOutput("pre_async", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1001, 4'b1111, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    checkOutput("post_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
